// File: rtl/alu_operand_regfile_if.sv
// Operand-fetch bus between the decode stage and the ALU register file.
interface alu_operand_regfile_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
);

  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          flags_en;
  logic [2:0]    flags_in;
  logic          flags_clr;
  logic [2:0]    flags_out;
  logic          carry_out;

  // Decode/ALU side: issues addresses, writes and flag updates
  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    output flags_en, flags_in, flags_clr,
    input  data_a, data_b, flags_out, carry_out
  );

  // Register-file side
  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    input  flags_en, flags_in, flags_clr,
    output data_a, data_b, flags_out, carry_out
  );

endinterface

// File: rtl/alu_operand_regfile.sv
// ALU operand register file: two async read ports with write bypass,
// one sync write port, and the {c,n,z} condition-flag register.
module alu_operand_regfile #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_operand_regfile_if.slave  bus
);

  localparam int unsigned NREGS = 2 ** AW;
  localparam int unsigned FW    = 3;

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic [FW-1:0] flags_q;
  logic [FW-1:0] flags_d;

  // Next array state: single write port, any register including r0
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.wr_en) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Next flag state: clear beats capture beats hold
  always_comb begin
    flags_d = flags_q;
    if (bus.flags_clr) begin
      flags_d = '0;
    end else if (bus.flags_en) begin
      flags_d = bus.flags_in;
    end
  end

  // Array register; reset wins over any pending write
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Flag register; reset wins over clear and capture
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Read ports forward same-cycle write data so dependent ops need no stall
  always_comb begin
    bus.data_a = regs_q[bus.rd_addr_a];
    bus.data_b = regs_q[bus.rd_addr_b];
    if (!reset && bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
      bus.data_a = bus.wr_data;
    end
    if (!reset && bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
      bus.data_b = bus.wr_data;
    end
  end

  // Flags are only ever seen from the register, never bypassed
  always_comb begin
    bus.flags_out = flags_q;
    bus.carry_out = flags_q[2];
  end

endmodule
